// File: rtl/noc_mem_responder.sv
// noc_mem_responder: NIU endpoint that services memory read/write request packets and returns response packets
module noc_mem_responder #(
  parameter logic [3:0] ADDR = 4'd0,
  parameter logic [3:0] PORT = 4'd0
) (
  input  logic         ipclk,
  input  logic         rst,
  input  logic         rx_av,
  output logic         rx_re,
  input  logic [287:0] rx_dat,
  output logic         tx_av,
  input  logic         tx_re,
  output logic [287:0] tx_dat,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [15:0]  mem_be,
  output logic [127:0] mem_wdat,
  input  logic         mem_ack,
  input  logic [127:0] mem_rdat,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, DECODE, MEM, RESP} state_t;
  state_t         state_q, state_d;
  logic [191:0]   req_q, req_d;
  logic [287:0]   tx_dat_q, tx_dat_d;
  logic           mem_we_q, mem_we_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [15:0]    mem_be_q, mem_be_d;
  logic [127:0]   mem_wdat_q, mem_wdat_d;
  logic [7:0]     len, op, n;
  logic [3:0]     a_lo;
  logic [4:0]     a_end;
  logic           valid;
  logic [15:0]    be;
  logic [127:0]   be_bits, rd_bits, rd_data;
  logic           unused_ok;
  assign unused_ok = ^{rx_dat[287:192], req_q[15:8]};
  function automatic logic [287:0] resp(input logic [7:0] l, input logic [7:0] o,
                                        input logic [7:0] src, input logic [127:0] d);
    return {128'b0, d, o, ADDR, PORT, src, l};
  endfunction
  // Write length carries N implicitly; a short write underflows n and fails the range check
  always_comb begin
    len   = req_q[7:0];
    op    = req_q[31:24];
    a_lo  = req_q[35:32];
    n     = op == 8'h01 ? req_q[71:64] : len - 8'd8;
    a_end = {1'b0, a_lo} + n[4:0];
    valid = ((op == 8'h01 && len == 8'd9) || op == 8'h02) && n != 8'd0 && n <= 8'd16 && a_end <= 5'd16;
    be      = '0;
    be_bits = '0;
    rd_bits = '0;
    for (int i = 0; i < 16; i++) begin
      be[i]           = 5'(i) >= {1'b0, a_lo} && 5'(i) < a_end;
      be_bits[8*i+:8] = {8{be[i]}};
      rd_bits[8*i+:8] = {8{5'(i) < n[4:0]}};
    end
    rd_data = (mem_rdat >> {a_lo, 3'b0}) & rd_bits;
  end
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    tx_dat_d   = tx_dat_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_be_d   = mem_be_q;
    mem_wdat_d = mem_wdat_q;
    rx_re      = 1'b0;
    case (state_q)
      IDLE: if (rx_av) begin
        rx_re   = 1'b1;
        req_d   = rx_dat[191:0];
        state_d = DECODE;
      end
      DECODE: if (valid) begin
        mem_we_d   = op == 8'h02;
        mem_addr_d = {req_q[63:36], 4'h0};
        mem_be_d   = op == 8'h02 ? be : 16'h0;
        mem_wdat_d = (req_q[191:64] << {a_lo, 3'b0}) & be_bits;
        state_d    = MEM;
      end else begin
        tx_dat_d = resp(8'd4, 8'hFF, req_q[23:16], 128'h0);
        state_d  = RESP;
      end
      MEM: if (mem_ack) begin
        tx_dat_d = mem_we_q ? resp(8'd4, 8'h82, req_q[23:16], 128'h0)
                            : resp(8'd4 + n, 8'h81, req_q[23:16], rd_data);
        state_d  = RESP;
      end
      RESP: state_d = tx_re ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ipclk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      tx_dat_q   <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_be_q   <= '0;
      mem_wdat_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      tx_dat_q   <= tx_dat_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_be_q   <= mem_be_d;
      mem_wdat_q <= mem_wdat_d;
    end
  end
  assign tx_av    = state_q == RESP && tx_re;
  assign tx_dat   = tx_dat_q;
  assign mem_req  = state_q == MEM;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_be   = mem_be_q;
  assign mem_wdat = mem_wdat_q;
  assign busy     = state_q != IDLE;
endmodule
